// File: rtl/jpeg_pkg.sv
// Shared JPEG stream definitions: marker bytes, packer state encoding and
// the accumulator geometry used by the bit packer and its accumulator.
package jpeg_pkg;

  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_EOI           = 8'hD9;
  localparam logic [7:0] JPEG_STUFF         = 8'h00;

  // Accumulator is 32 bits, left-aligned; fill count runs 0..31.
  localparam int ACC_W  = 32;
  localparam int FILL_W = 5;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    STUFF   = 3'd1,
    PAD     = 3'd2,
    STUFF_P = 3'd3,
    MARK_FF = 3'd4,
    MARK_D9 = 3'd5,
    DONE    = 3'd6
  } pack_state_t;

  // Final partial byte: keep the top 'fill' bits, force every bit below to 1.
  // Only meaningful for fill in 1..7.
  function automatic logic [7:0] pad_ones(input logic [7:0] top_byte,
                                          input logic [FILL_W-1:0] fill);
    return top_byte | (8'hFF >> fill);
  endfunction

endpackage

// File: rtl/jpeg_bit_acc.sv
// Left-aligned bit accumulator for the JPEG bit packer. Appends right-aligned
// codes below the existing fill, shifts out whole bytes from the top, and can
// be cleared after the final padded byte. Exposes next-cycle values so the
// packer can register its outputs from them.
module jpeg_bit_acc
  import jpeg_pkg::*;
#(
  parameter int CODE_W = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              append_en,
  input  logic [CODE_W-1:0] code,
  input  logic [FILL_W-1:0] append_len,
  input  logic              shift_en,
  input  logic              clear_en,
  output logic [FILL_W-1:0] fill_r,
  output logic [FILL_W-1:0] fill_nxt_s,
  output logic [7:0]        top_nxt_s
);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_nxt_s;
  logic [ACC_W-1:0] code_ext_s;
  logic [ACC_W-1:0] len_mask_s;
  logic [ACC_W-1:0] placed_s;

  // Align the masked code so its MSB lands just below the current fill, then pick the update.
  always_comb begin
    code_ext_s = ACC_W'(code);
    len_mask_s = (32'd1 << append_len) - 32'd1;
    placed_s   = ((code_ext_s & len_mask_s) << (6'd32 - {1'b0, append_len})) >> fill_r;
    acc_nxt_s  = acc_r;
    fill_nxt_s = fill_r;
    if (clear_en) begin
      acc_nxt_s  = '0;
      fill_nxt_s = '0;
    end else if (shift_en) begin
      acc_nxt_s  = acc_r << 4'd8;
      fill_nxt_s = fill_r - 5'd8;
    end else if (append_en) begin
      acc_nxt_s  = acc_r | placed_s;
      fill_nxt_s = fill_r + append_len;
    end else begin
      acc_nxt_s  = acc_r;
      fill_nxt_s = fill_r;
    end
    top_nxt_s = acc_nxt_s[ACC_W-1:ACC_W-8];
  end

  // Accumulator and fill count registers; bits below fill are always zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_r  <= '0;
      fill_r <= '0;
    end else begin
      acc_r  <= acc_nxt_s;
      fill_r <= fill_nxt_s;
    end
  end

endmodule

// File: rtl/jpeg_bit_packer.sv
// JPEG entropy bit packer: packs variable-length codes MSB-first into bytes,
// stuffs 0x00 after every 0xFF data byte, and on flush pads the last partial
// byte with 1s and optionally appends the EOI marker FF D9.
// All outputs are registered from the next-cycle state so a code that
// completes a byte shows byte_valid on the following cycle.
module jpeg_bit_packer
  import jpeg_pkg::*;
#(
  parameter int CODE_W   = 24,
  parameter int LEN_W    = 8,
  parameter bit EMIT_EOI = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [CODE_W-1:0] code,
  input  logic [LEN_W-1:0]  code_len,
  input  logic              flush,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [7:0]        byte_data,
  output logic              flush_done,
  output logic              len_err
);

  // After the padded byte (and its stuff byte) the stream either gets EOI or ends.
  localparam pack_state_t TAIL_ST = EMIT_EOI ? MARK_FF : DONE;

  pack_state_t       state_r;
  pack_state_t       state_nxt_s;
  logic              flush_pend_r;
  logic              flush_pend_nxt_s;
  logic              code_ready_r;
  logic              byte_valid_r;
  logic [7:0]        byte_data_r;
  logic              flush_done_r;
  logic              len_err_r;

  logic              accept_s;
  logic              xfer_s;
  logic              len_over_s;
  logic [FILL_W-1:0] len_eff_s;
  logic              shift_s;
  logic              clear_s;
  logic [FILL_W-1:0] fill_r;
  logic [FILL_W-1:0] fill_nxt_s;
  logic [7:0]        top_nxt_s;
  logic              pres_valid_s;
  logic [7:0]        pres_data_s;
  logic              ready_nxt_s;

  assign accept_s   = code_valid && code_ready_r;
  assign xfer_s     = byte_valid_r && byte_ready;

  assign code_ready = code_ready_r;
  assign byte_valid = byte_valid_r;
  assign byte_data  = byte_data_r;
  assign flush_done = flush_done_r;
  assign len_err    = len_err_r;

  // Clamp over-long codes to the maximum code width.
  always_comb begin
    len_over_s = (code_len > LEN_W'(CODE_W));
    if (len_over_s) begin
      len_eff_s = FILL_W'(CODE_W);
    end else begin
      len_eff_s = code_len[FILL_W-1:0];
    end
  end

  jpeg_bit_acc #(
    .CODE_W (CODE_W)
  ) u_acc (
    .clock      (clock),
    .reset      (reset),
    .append_en  (accept_s),
    .code       (code),
    .append_len (len_eff_s),
    .shift_en   (shift_s),
    .clear_en   (clear_s),
    .fill_r     (fill_r),
    .fill_nxt_s (fill_nxt_s),
    .top_nxt_s  (top_nxt_s)
  );

  // Next-state logic: advance on byte transfer, walk the flush tail, drive accumulator controls.
  always_comb begin
    state_nxt_s = state_r;
    shift_s     = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      RUN: begin
        if (fill_r >= 5'd8) begin
          if (xfer_s) begin
            shift_s = 1'b1;
            if (byte_data_r == JPEG_MARKER_PREFIX) begin
              state_nxt_s = STUFF;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end else if (flush_pend_r) begin
          state_nxt_s = PAD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      STUFF: begin
        if (xfer_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = STUFF;
        end
      end
      PAD: begin
        if (fill_r != 5'd0) begin
          if (xfer_s) begin
            clear_s = 1'b1;
            if (byte_data_r == JPEG_MARKER_PREFIX) begin
              state_nxt_s = STUFF_P;
            end else begin
              state_nxt_s = TAIL_ST;
            end
          end else begin
            state_nxt_s = PAD;
          end
        end else begin
          state_nxt_s = TAIL_ST;
        end
      end
      STUFF_P: begin
        if (xfer_s) begin
          state_nxt_s = TAIL_ST;
        end else begin
          state_nxt_s = STUFF_P;
        end
      end
      MARK_FF: begin
        if (xfer_s) begin
          state_nxt_s = MARK_D9;
        end else begin
          state_nxt_s = MARK_FF;
        end
      end
      MARK_D9: begin
        if (xfer_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = MARK_D9;
        end
      end
      DONE: begin
        state_nxt_s = RUN;
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // Pending-flush flag: drops on entry to DONE so code_ready can return with flush_done.
  always_comb begin
    if ((state_nxt_s == DONE) && (state_r != DONE)) begin
      flush_pend_nxt_s = 1'b0;
    end else if (flush && !flush_pend_r) begin
      flush_pend_nxt_s = 1'b1;
    end else begin
      flush_pend_nxt_s = flush_pend_r;
    end
  end

  // Byte presented in the next cycle, derived from next state and accumulator contents.
  always_comb begin
    pres_valid_s = 1'b0;
    pres_data_s  = 8'h00;
    case (state_nxt_s)
      RUN: begin
        if (fill_nxt_s >= 5'd8) begin
          pres_valid_s = 1'b1;
          pres_data_s  = top_nxt_s;
        end else begin
          pres_valid_s = 1'b0;
        end
      end
      STUFF, STUFF_P: begin
        pres_valid_s = 1'b1;
        pres_data_s  = JPEG_STUFF;
      end
      PAD: begin
        if (fill_nxt_s != 5'd0) begin
          pres_valid_s = 1'b1;
          pres_data_s  = pad_ones(top_nxt_s, fill_nxt_s);
        end else begin
          pres_valid_s = 1'b0;
        end
      end
      MARK_FF: begin
        pres_valid_s = 1'b1;
        pres_data_s  = JPEG_MARKER_PREFIX;
      end
      MARK_D9: begin
        pres_valid_s = 1'b1;
        pres_data_s  = JPEG_EOI;
      end
      default: begin
        pres_valid_s = 1'b0;
      end
    endcase
    ready_nxt_s = ((state_nxt_s == RUN) || (state_nxt_s == DONE)) &&
                  (fill_nxt_s < 5'd8) && !flush_pend_nxt_s;
  end

  // State register and registered handshake/status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= RUN;
      flush_pend_r <= 1'b0;
      code_ready_r <= 1'b1;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'h00;
      flush_done_r <= 1'b0;
      len_err_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      flush_pend_r <= flush_pend_nxt_s;
      code_ready_r <= ready_nxt_s;
      byte_valid_r <= pres_valid_s;
      byte_data_r  <= pres_data_s;
      flush_done_r <= (state_nxt_s == DONE);
      len_err_r    <= len_err_r | (accept_s && len_over_s);
    end
  end

endmodule
